reset_sequencer: RTL and testbench

- Owns reset for the CPU clock domain on the Z1 top level.
- Combines PLL lock, debounced reset-button pulse and a CPU-issued software reset request into ordered reset outputs: the peripheral reset releases first, then the CPU reset.
- Keeps a sticky reset-cause register and a reset counter so software can read why it restarted.
- Sits between the PLL/button_parser and Riscv151 plus its MMIO peripherals.

---
 rtl/reset_sequencer_if.sv | 22 ++
 rtl/reset_sequencer.sv | 122 ++++++++++++
 tb/tb_reset_sequencer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/reset_sequencer_if.sv
// Reset sequencer side-band bundle: lock/reset requests in, ordered resets and status out.
interface reset_sequencer_if;
  logic       pll_locked;
  logic       button_reset;
  logic       sw_reset_req;
  logic       cause_clear;
  logic       periph_rst;
  logic       cpu_rst;
  logic       ready;
  logic [2:0] reset_cause;
  logic [7:0] reset_count;

  modport master (
    output pll_locked, button_reset, sw_reset_req, cause_clear,
    input  periph_rst, cpu_rst, ready, reset_cause, reset_count
  );

  modport slave (
    input  pll_locked, button_reset, sw_reset_req, cause_clear,
    output periph_rst, cpu_rst, ready, reset_cause, reset_count
  );
endinterface

// File: rtl/reset_sequencer.sv
// CPU-domain reset owner: waits for stable PLL lock, releases peripherals then CPU,
// and records why the last reset happened.
module reset_sequencer #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int PERIPH_LEAD_CYCLES = 8,
  parameter int HOLD_CYCLES        = 16,
  parameter int SYNC_STAGES        = 2,
  parameter int CNT_WIDTH          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  reset_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {WAIT_LOCK, PERIPH_REL, RUN, HOLD} state_t;

  localparam logic [CNT_WIDTH-1:0] LOCK_LAST = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] LEAD_LAST = CNT_WIDTH'(PERIPH_LEAD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  state_t                 state, state_d;
  logic [CNT_WIDTH-1:0]   cnt, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic                   periph_q, periph_d;
  logic                   cpu_q, cpu_d;
  logic                   ready_q, ready_d;
  logic [2:0]             cause_q, cause_d;
  logic [7:0]             count_q, count_d;
  logic [2:0]             evt_bits;
  logic                   evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
  end

  assign lock_s   = sync_q[SYNC_STAGES-1];
  // Bit order matches reset_cause: {sw, button, lock_loss}.
  assign evt_bits = {bus.sw_reset_req, bus.button_reset, ~lock_s};
  assign evt      = |evt_bits;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    cause_d = bus.cause_clear ? 3'b000 : cause_q;
    count_d = count_q;
    case (state)
      WAIT_LOCK: begin
        if (!lock_s) begin
          cnt_d = '0;
        end else if (cnt == LOCK_LAST) begin
          state_d = PERIPH_REL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end
      PERIPH_REL, RUN: begin
        if (evt) begin
          state_d = HOLD;
          cnt_d   = '0;
          cause_d = cause_d | evt_bits;
          if (count_q != 8'hFF) count_d = count_q + 8'd1;
        end else if (state == PERIPH_REL) begin
          if (cnt == LEAD_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + CNT_ONE;
          end
        end
      end
      HOLD: begin
        // Further requests only stretch the hold; they are not new reset events.
        if (bus.button_reset || bus.sw_reset_req) begin
          cnt_d = '0;
        end else if (cnt == HOLD_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
    periph_d = (state_d == WAIT_LOCK) || (state_d == HOLD);
    cpu_d    = (state_d != RUN);
    ready_d  = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= WAIT_LOCK;
      cnt      <= '0;
      periph_q <= 1'b1;
      cpu_q    <= 1'b1;
      ready_q  <= 1'b0;
      cause_q  <= 3'b000;
      count_q  <= 8'd0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      periph_q <= periph_d;
      cpu_q    <= cpu_d;
      ready_q  <= ready_d;
      cause_q  <= cause_d;
      count_q  <= count_d;
    end
  end

  assign bus.periph_rst  = periph_q;
  assign bus.cpu_rst     = cpu_q;
  assign bus.ready       = ready_q;
  assign bus.reset_cause = cause_q;
  assign bus.reset_count = count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with short timing parameters (4/2/3/2).
module tb_reset_sequencer;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  reset_sequencer_if bus ();

  reset_sequencer #(
    .LOCK_STABLE_CYCLES(4),
    .PERIPH_LEAD_CYCLES(2),
    .HOLD_CYCLES       (3),
    .SYNC_STAGES       (2),
    .CNT_WIDTH         (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Event sampled at edge E (current point): periph falls after E+7, cpu after E+9.
  task automatic recover(input string tag);
    tick(6); chk({tag, "_p6"}, bus.periph_rst, 1);
    tick(1); chk({tag, "_p7"}, bus.periph_rst, 0); chk({tag, "_c7"}, bus.cpu_rst, 1);
    tick(2); chk({tag, "_c9"}, bus.cpu_rst, 0);    chk({tag, "_r9"}, bus.ready, 1);
  endtask

  // Async reset with no clock edge, then power-up with pll rising after edge d.
  task automatic power_up(input string tag, input int d);
    rst_n = 1'b0;
    bus.pll_locked = (d == 0);
    #2;
    chk({tag, "_rst_p"}, bus.periph_rst, 1);
    chk({tag, "_rst_c"}, bus.cpu_rst, 1);
    chk({tag, "_rst_r"}, bus.ready, 0);
    chk({tag, "_rst_cause"}, bus.reset_cause, 0);
    chk({tag, "_rst_cnt"}, bus.reset_count, 0);
    rst_n = 1'b1;
    if (d > 0) begin
      tick(d);
      bus.pll_locked = 1'b1;
    end
    tick(5); chk({tag, "_p5"}, bus.periph_rst, 1);
    tick(1); chk({tag, "_p6"}, bus.periph_rst, 0);
    chk({tag, "_c6"}, bus.cpu_rst, 1); chk({tag, "_r6"}, bus.ready, 0);
    tick(1); chk({tag, "_c7"}, bus.cpu_rst, 1);
    tick(1); chk({tag, "_c8"}, bus.cpu_rst, 0); chk({tag, "_r8"}, bus.ready, 1);
    chk({tag, "_cause"}, bus.reset_cause, 0);
    chk({tag, "_cnt"}, bus.reset_count, 0);
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.pll_locked   = 1'b1;
    bus.button_reset = 1'b0;
    bus.sw_reset_req = 1'b0;
    bus.cause_clear  = 1'b0;
    @(posedge clk);
    #1;

    power_up("pwr0", 0);
    power_up("pwr3", 3);

    // button in RUN
    bus.button_reset = 1'b1; tick(1); bus.button_reset = 1'b0;
    chk("btn_p", bus.periph_rst, 1); chk("btn_c", bus.cpu_rst, 1);
    chk("btn_r", bus.ready, 0);
    chk("btn_cause", bus.reset_cause, 3'b010); chk("btn_cnt", bus.reset_count, 1);
    recover("btn");

    bus.cause_clear = 1'b1; tick(1); bus.cause_clear = 1'b0;
    chk("clr_cause", bus.reset_cause, 0); chk("clr_r", bus.ready, 1);

    // one-cycle lock dropout in RUN
    bus.pll_locked = 1'b0; tick(1); bus.pll_locked = 1'b1;
    chk("lock_e0", bus.ready, 1);
    tick(1); chk("lock_e1", bus.ready, 1);
    tick(1); chk("lock_e2_r", bus.ready, 0); chk("lock_e2_p", bus.periph_rst, 1);
    chk("lock_cause", bus.reset_cause, 3'b001); chk("lock_cnt", bus.reset_count, 2);
    recover("lock");

    // sw request with cause_clear together, then dropout while counting lock
    bus.sw_reset_req = 1'b1; bus.cause_clear = 1'b1; tick(1);
    bus.sw_reset_req = 1'b0; bus.cause_clear = 1'b0;
    chk("swclr_cause", bus.reset_cause, 3'b100); chk("swclr_cnt", bus.reset_count, 3);
    tick(4); bus.pll_locked = 1'b0;
    tick(1); bus.pll_locked = 1'b1;
    tick(2); chk("wdrop_p7", bus.periph_rst, 1);
    tick(3); chk("wdrop_p10", bus.periph_rst, 1);
    tick(1); chk("wdrop_p11", bus.periph_rst, 0); chk("wdrop_c11", bus.cpu_rst, 1);
    tick(2); chk("wdrop_c13", bus.cpu_rst, 0); chk("wdrop_r13", bus.ready, 1);
    chk("wdrop_cause", bus.reset_cause, 3'b100);

    // simultaneous causes, then hold extension
    bus.cause_clear = 1'b1; tick(1); bus.cause_clear = 1'b0;
    chk("clr2_cause", bus.reset_cause, 0);
    bus.sw_reset_req = 1'b1; bus.button_reset = 1'b1; tick(1);
    bus.sw_reset_req = 1'b0; bus.button_reset = 1'b0;
    chk("both_cause", bus.reset_cause, 3'b110); chk("both_cnt", bus.reset_count, 4);
    tick(1); bus.button_reset = 1'b1; tick(1); bus.button_reset = 1'b0;
    chk("ext_cnt", bus.reset_count, 4); chk("ext_cause", bus.reset_cause, 3'b110);
    chk("ext_p", bus.periph_rst, 1);
    recover("ext");

    // async reset in PERIPH_REL
    bus.sw_reset_req = 1'b1; tick(1); bus.sw_reset_req = 1'b0;
    chk("pr_cnt", bus.reset_count, 5);
    tick(7); chk("pr_p", bus.periph_rst, 0); chk("pr_c", bus.cpu_rst, 1);
    power_up("pwr_mid", 0);

    // saturation
    for (int i = 1; i <= 300; i++) begin
      bus.sw_reset_req = 1'b1; tick(1); bus.sw_reset_req = 1'b0;
      chk("sat_cnt", bus.reset_count, (i > 255) ? 255 : i);
      chk("sat_cause", bus.reset_cause, 3'b100);
      tick(9);
      chk("sat_run", bus.ready, 1);
    end
    chk("sat_final", bus.reset_count, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
